// File: rtl/sp_sram_init_model.sv
// Behavioural single-port SRAM with per-group write mask, 1/2-cycle read latency and init-on-reset.
// Optional define SP_SRAM_RAND_Q_EN: Q loads random data on every non-read RUN cycle.
module sp_sram_init_model #(
    parameter int unsigned     BITS     = 16,
    parameter int unsigned     DEPTH    = 256,
    parameter int unsigned     ADDR_W   = 8,
    parameter int unsigned     MASK_W   = 2,
    parameter int unsigned     RD_LAT   = 1,
    parameter logic [BITS-1:0] INIT_VAL = '0
) (
    input  logic              CLK,
    input  logic              RSTB,
    input  logic              CEB,
    input  logic              WEB,
    input  logic [MASK_W-1:0] BWEB,
    input  logic [ADDR_W-1:0] A,
    input  logic [BITS-1:0]   D,
    output logic [BITS-1:0]   Q,
    output logic              BUSY
);

    localparam int unsigned       G    = BITS / MASK_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              busy_q;
    logic [BITS-1:0]   q_q;
    logic [BITS-1:0]   stage_q;
    logic              stage_vld_q;
    logic [BITS-1:0]   ram [DEPTH];

    logic a_in_range;
    logic rd_fire;
    logic wr_fire;

`ifdef SP_SRAM_RAND_Q_EN
    function automatic logic [BITS-1:0] rand_word();
        logic [(BITS/32+1)*32-1:0] r;
        r = '0;
        for (int unsigned k = 0; k < BITS/32 + 1; k++) begin
            r[k*32 +: 32] = $random;
        end
        return r[BITS-1:0];
    endfunction
`endif

    // Data returned for an address beyond DEPTH.
    function automatic logic [BITS-1:0] oob_word();
`ifdef SP_SRAM_RAND_Q_EN
        return rand_word();
`else
        return 'x;
`endif
    endfunction

    always_comb begin
        a_in_range = (32'(A) < DEPTH);
        rd_fire    = (state_q == ST_RUN) && !CEB && WEB;
        wr_fire    = (state_q == ST_RUN) && !CEB && !WEB && a_in_range;
    end

    // Array has no reset: reset cycles leave contents alone, INIT rewrites them afterwards.
    always_ff @(posedge CLK) begin
        if (RSTB) begin
            if (state_q == ST_INIT) begin
                ram[cnt_q] <= INIT_VAL;
            end else if (wr_fire) begin
                for (int unsigned i = 0; i < MASK_W; i++) begin
                    if (!BWEB[i]) begin
                        ram[A][i*G +: G] <= D[i*G +: G];
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTB) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            busy_q      <= 1'b1;
            q_q         <= '0;
            stage_vld_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    cnt_q <= cnt_q + ADDR_W'(1);
                    if (cnt_q == LAST) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    stage_vld_q <= rd_fire;
                    if (rd_fire) begin
                        stage_q <= a_in_range ? ram[A] : oob_word();
                    end
                    if (RD_LAT == 1 && rd_fire) begin
                        q_q <= a_in_range ? ram[A] : oob_word();
                    end else if (RD_LAT != 1 && stage_vld_q) begin
                        q_q <= stage_q;
                    end
`ifdef SP_SRAM_RAND_Q_EN
                    else begin
                        q_q <= rand_word();
                    end
`endif
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    assign Q    = q_q;
    assign BUSY = busy_q;

endmodule

// File: tb/tb_sp_sram_init_model.sv
// Bench for sp_sram_init_model: a default instance plus a 200-deep, 4-group, 2-cycle-latency
// instance share stimulus and are checked against array-based reference models.
module tb_sp_sram_init_model;

    logic        CLK;
    logic        RSTB;
    logic        CEB;
    logic        WEB;
    logic [1:0]  BWEB1;
    logic [3:0]  BWEB2;
    logic [7:0]  A;
    logic [15:0] D;
    logic [15:0] Q1;
    logic [15:0] Q2;
    logic        BUSY1;
    logic        BUSY2;

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [15:0] m1 [256];
    logic [15:0] m2 [256];
    int          left1 = 0;
    int          left2 = 0;
    logic [15:0] q1e = '0;
    logic [15:0] q2e = '0;
    logic [15:0] pend = '0;
    bit          pend_v = 1'b0;

    sp_sram_init_model dut1 (
        .CLK(CLK), .RSTB(RSTB), .CEB(CEB), .WEB(WEB), .BWEB(BWEB1),
        .A(A), .D(D), .Q(Q1), .BUSY(BUSY1)
    );

    sp_sram_init_model #(
        .BITS(16), .DEPTH(200), .ADDR_W(8), .MASK_W(4), .RD_LAT(2), .INIT_VAL(16'h5A5A)
    ) dut2 (
        .CLK(CLK), .RSTB(RSTB), .CEB(CEB), .WEB(WEB), .BWEB(BWEB2),
        .A(A), .D(D), .Q(Q2), .BUSY(BUSY2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                          input logic [15:0] wmask);
        return (old & ~wmask) | (d & wmask);
    endfunction

    // One clock: advance the reference model with the current inputs, then compare after the edge.
    task automatic tick();
        logic [15:0] wm;
        if (!RSTB) begin
            left1  = 256;
            left2  = 200;
            q1e    = '0;
            q2e    = '0;
            pend_v = 1'b0;
        end else begin
            if (left1 > 0) begin
                m1[256-left1] = 16'h0000;
                left1--;
            end else if (!CEB && !WEB) begin
                wm = {{8{~BWEB1[1]}}, {8{~BWEB1[0]}}};
                m1[A] = merge(m1[A], D, wm);
            end else if (!CEB) begin
                q1e = m1[A];
            end

            if (pend_v) q2e = pend;
            pend_v = 1'b0;
            if (left2 > 0) begin
                m2[200-left2] = 16'h5A5A;
                left2--;
            end else if (!CEB && !WEB) begin
                wm = {{4{~BWEB2[3]}}, {4{~BWEB2[2]}}, {4{~BWEB2[1]}}, {4{~BWEB2[0]}}};
                if (A < 8'd200) m2[A] = merge(m2[A], D, wm);
            end else if (!CEB) begin
                pend   = (A < 8'd200) ? m2[A] : 16'hxxxx;
                pend_v = 1'b1;
            end
        end
        @(posedge CLK);
        #1;
        check("Q1", Q1, q1e);
        check("Q2", Q2, q2e);
        check("BUSY1", 16'(BUSY1), 16'(left1 > 0));
        check("BUSY2", 16'(BUSY2), 16'(left2 > 0));
    endtask

    task automatic idle();
        CEB = 1'b1; WEB = 1'b1; BWEB1 = '1; BWEB2 = '1;
        tick();
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d,
                      input logic [1:0] b1, input logic [3:0] b2);
        CEB = 1'b0; WEB = 1'b0; A = a; D = d; BWEB1 = b1; BWEB2 = b2;
        tick();
    endtask

    task automatic rd(input logic [7:0] a);
        CEB = 1'b0; WEB = 1'b1; A = a; BWEB1 = '1; BWEB2 = '1;
        tick();
    endtask

    initial begin
        int n;
        RSTB = 1'b0; CEB = 1'b1; WEB = 1'b1; BWEB1 = '1; BWEB2 = '1; A = '0; D = '0;

        // Reset for 3 cycles: BUSY high, Q cleared
        repeat (3) tick();
        check("RST_Q1", Q1, 16'h0000);
        check("RST_BUSY1", 16'(BUSY1), 16'h0001);

        // Init sweep; a write attempted at cnt=100 must be ignored
        RSTB = 1'b1;
        for (int i = 0; i < 256; i++) begin
            if (i == 100) wr(8'h05, 16'hFFFF, 2'b00, 4'b0000);
            else idle();
            if (i == 254) check("T1_BUSY_BEFORE_LAST", 16'(BUSY1), 16'h0001);
        end
        check("T1_BUSY_FALL", 16'(BUSY1), 16'h0000);
        check("T1_Q_AFTER_INIT", Q1, 16'h0000);

        // Every word reads INIT_VAL
        for (int a = 0; a < 256; a++) begin
            rd(8'(a));
            if (a == 5) check("T4_A5_INIT", Q1, 16'h0000);
        end
        idle();

        // Masked write then read
        wr(8'h10, 16'hABCD, 2'b00, 4'b0000);
        wr(8'h10, 16'h1234, 2'b10, 4'b1100);
        rd(8'h10);
        check("T2_Q1", Q1, 16'hAB34);
        idle();
        check("T2_Q2", Q2, 16'hAB34);

        // Back-to-back reads through the 2-cycle pipe
        wr(8'h01, 16'h0001, 2'b00, 4'b0000);
        wr(8'h02, 16'h0002, 2'b00, 4'b0000);
        wr(8'h03, 16'h0003, 2'b00, 4'b0000);
        rd(8'h01);
        rd(8'h02);
        check("T3_Q2_E2", Q2, 16'h0001);
        rd(8'h03);
        check("T3_Q2_E3", Q2, 16'h0002);
        idle();
        check("T3_Q2_E4", Q2, 16'h0003);
        idle();
        check("T3_Q2_HOLD", Q2, 16'h0003);

        // Out-of-range write on the 200-deep instance is dropped, read gives X
        wr(8'd210, 16'h7777, 2'b00, 4'b0000);
        rd(8'd210);
        idle();
        check("OOB_Q2_X", Q2, 16'hxxxx);

        // Random traffic
        repeat (800) begin
            CEB   = ($urandom_range(0, 3) == 0);
            WEB   = $urandom_range(0, 1) == 1;
            A     = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
            D     = 16'($urandom);
            BWEB1 = 2'($urandom);
            BWEB2 = 4'($urandom);
            tick();
        end
        idle();
        idle();

        // Reset in RUN, then again mid-init at cnt=128
        RSTB = 1'b0;
        idle();
        check("T5_Q_CLEARED", Q1, 16'h0000);
        RSTB = 1'b1;
        repeat (128) idle();
        RSTB = 1'b0;
        idle();
        RSTB = 1'b1;
        n = 0;
        while (BUSY1 && n < 300) begin
            idle();
            n++;
        end
        check("T5_BUSY_LEN", 16'(n), 16'd256);

        // Contents re-initialised
        repeat (60) rd(8'($urandom_range(0, 255)));
        rd(8'h10);
        check("T5_A10_REINIT", Q1, 16'h0000);
        idle();
        check("T5_A10_REINIT_Q2", Q2, 16'h5A5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
